// File: rtl/seq_div_32.sv
// Multi-cycle signed non-restoring divider; result = {remainder, quotient}.
// Define SEQ_DIV_UNSIGNED_EN to add the signed_op port for unsigned division.
module seq_div_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
`ifdef SEQ_DIV_UNSIGNED_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  logic               sop_in;

`ifdef SEQ_DIV_UNSIGNED_EN
  assign sop_in = signed_op;
`else
  assign sop_in = 1'b1;
`endif

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rsync_q;
  logic [1:0] rsync_d;
  logic       rst_n;

  assign rsync_d = {rsync_q[0], 1'b1};
  assign rst_n   = rsync_q[1];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) rsync_q <= '0;
    else        rsync_q <= rsync_d;
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sop_q, sop_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;

  logic               sa, sb;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     rem_n;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   q_res;
  logic [WIDTH-1:0]   r_res;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sop_d    = sop_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    zero_d   = zero_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    sa       = 1'b0;
    sb       = 1'b0;
    shifted  = '0;
    rem_n    = '0;
    rem_fix  = '0;
    q_res    = '0;
    r_res    = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_PREP;
          a_d     = dividend;
          b_d     = divisor;
          sop_d   = sop_in;
        end
      end
      S_PREP: begin
        sa      = sop_q & a_q[WIDTH-1];
        sb      = sop_q & b_q[WIDTH-1];
        quo_d   = sa ? -a_q : a_q;
        dsr_d   = sb ? -b_q : b_q;
        negq_d  = sa ^ sb;
        negr_d  = sa;
        zero_d  = (b_q == '0);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        // Partial remainder sign picks add vs subtract for this step.
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        if (rem_q[WIDTH]) rem_n = shifted + {1'b0, dsr_q};
        else              rem_n = shifted - {1'b0, dsr_q};
        rem_d = rem_n;
        quo_d = {quo_q[WIDTH-2:0], ~rem_n[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (rem_q[WIDTH]) rem_fix = rem_q[WIDTH-1:0] + dsr_q;
        else              rem_fix = rem_q[WIDTH-1:0];
        q_res = negq_q ? -quo_q : quo_q;
        r_res = negr_q ? -rem_fix : rem_fix;
        dbz_d = 1'b0;
        if (zero_q) begin
          q_res = '1;
          r_res = a_q;
          dbz_d = 1'b1;
        end
        result_d = {r_res, q_res};
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sop_q    <= 1'b0;
      quo_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sop_q    <= sop_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_PREP) || (state_q == S_ITER) ||
                       (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
